sram_cache_ctrl: RTL and testbench

- Parametrised 2-way set-associative, write-through, no-write-allocate data cache.
- Sits between the MEM stage (CPU side) and a line-wide SRAM controller (memory side).
- Reads that hit return the word in the same cycle. Misses and all writes stall the pipeline through `ready`.
- Adds per-set LRU replacement and saturating hit/miss statistics counters.

---
 rtl/sram_cache_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sram_cache_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sram_cache_ctrl.sv
// 2-way set-associative, write-through, no-write-allocate data cache between the
// MEM stage and a line-wide SRAM controller, with per-set LRU and hit/miss counters.
module sram_cache_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int          SET_BITS  = 6,
  parameter int          TAG_BITS  = 10,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 ready,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [63:0]          mem_rdata,
  input  logic                 mem_ready,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int SETS    = 1 << SET_BITS;
  localparam int TAG_LSB = SET_BITS + 3;
  localparam int TAG_MSB = TAG_LSB + TAG_BITS - 1;

  typedef enum logic [1:0] {IDLE, MISS, WRITE} state_t;

  state_t state;
  logic   req_word;

  logic [1:0][SETS-1:0] valid;
  logic [SETS-1:0]      lru;
  logic [TAG_BITS-1:0]  tag_mem  [2][SETS];
  logic [63:0]          data_mem [2][SETS];

  logic [31:0]          eff;
  logic [31:0]          dec_addr;
  logic [SET_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]  tag;
  logic                 word_sel;
  logic                 hit0, hit1, any_hit, hit_way, fill_way;
  logic [63:0]          hit_line;
  logic                 unused_bits;

  // Outside IDLE the request address lives in mem_addr, so decode from there.
  assign eff      = cpu_addr - BASE_ADDR;
  assign dec_addr = (state == IDLE) ? eff : mem_addr;
  assign idx      = dec_addr[SET_BITS+2:3];
  assign tag      = dec_addr[TAG_MSB:TAG_LSB];
  assign word_sel = (state == IDLE) ? eff[2] : req_word;

  assign hit0     = valid[0][idx] && (tag_mem[0][idx] == tag);
  assign hit1     = valid[1][idx] && (tag_mem[1][idx] == tag);
  assign any_hit  = hit0 | hit1;
  assign hit_way  = hit1;
  assign fill_way = lru[idx];
  assign hit_line = data_mem[hit_way][idx];

  assign unused_bits = ^{dec_addr[31:TAG_MSB+1], dec_addr[2:0]};

  always_comb begin
    ready     = 1'b1;
    cpu_rdata = '0;
    case (state)
      IDLE: begin
        if (cpu_wr) begin
          ready = 1'b0;
        end else if (cpu_rd) begin
          if (any_hit) begin
            cpu_rdata = word_sel ? hit_line[63:32] : hit_line[31:0];
          end else begin
            ready = 1'b0;
          end
        end
      end
      MISS: begin
        ready = mem_ready;
        if (mem_ready) begin
          cpu_rdata = word_sel ? mem_rdata[63:32] : mem_rdata[31:0];
        end
      end
      WRITE: ready = mem_ready;
      default: ready = 1'b1;
    endcase
    if (rst) begin
      cpu_rdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      lru        <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      req_word   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_wr) begin
            mem_wr    <= 1'b1;
            mem_addr  <= eff;
            mem_wdata <= cpu_wdata;
            req_word  <= eff[2];
            state     <= WRITE;
          end else if (cpu_rd) begin
            if (any_hit) begin
              lru[idx] <= ~hit_way;
              if (hit_count != '1) begin
                hit_count <= hit_count + 1'b1;
              end
            end else begin
              mem_rd   <= 1'b1;
              mem_addr <= {eff[31:3], 3'b000};
              req_word <= eff[2];
              state    <= MISS;
            end
          end
        end
        MISS: begin
          if (mem_ready) begin
            valid[fill_way][idx] <= 1'b1;
            lru[idx]             <= ~fill_way;
            if (miss_count != '1) begin
              miss_count <= miss_count + 1'b1;
            end
            mem_rd <= 1'b0;
            state  <= IDLE;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            if (any_hit) begin
              lru[idx] <= ~hit_way;
            end
            mem_wr <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == MISS && mem_ready) begin
        data_mem[fill_way][idx] <= mem_rdata;
        tag_mem[fill_way][idx]  <= tag;
      end else if (state == WRITE && mem_ready && any_hit) begin
        if (req_word) begin
          data_mem[hit_way][idx][63:32] <= mem_wdata;
        end else begin
          data_mem[hit_way][idx][31:0] <= mem_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_cache_ctrl.sv
// Directed self-checking bench for sram_cache_ctrl; acts as the SRAM controller by hand.
module tb_sram_cache_ctrl;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_rd, cpu_wr;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          ready, mem_rd, mem_wr, mem_ready;
  logic [31:0]   mem_addr, mem_wdata;
  logic [63:0]   mem_rdata;
  logic [CW-1:0] hit_count, miss_count;

  int checks   = 0;
  int failures = 0;

  sram_cache_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .ready(ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata);
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    #1;
  endtask

  task automatic wait_mem(input logic want_wr);
    for (int i = 0; i < 4 && !(want_wr ? mem_wr : mem_rd); i++) tick();
  endtask

  task automatic read_miss(input string tag, input logic [31:0] addr, input logic [31:0] line_addr,
                           input logic [63:0] line, input logic [31:0] exp);
    applyStimulus(1'b1, 1'b0, addr, 32'h0);
    checkOutput({tag, ".stall"}, ready, 0);
    wait_mem(1'b0);
    checkOutput({tag, ".mem_rd"}, mem_rd, 1);
    checkOutput({tag, ".mem_addr"}, mem_addr, line_addr);
    mem_rdata = line;
    mem_ready = 1'b1;
    #1;
    checkOutput({tag, ".ready"}, ready, 1);
    checkOutput({tag, ".rdata"}, cpu_rdata, exp);
    tick();
    mem_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput({tag, ".mem_rd_low"}, mem_rd, 0);
  endtask

  task automatic read_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    applyStimulus(1'b1, 1'b0, addr, 32'h0);
    checkOutput({tag, ".ready"}, ready, 1);
    checkOutput({tag, ".rdata"}, cpu_rdata, exp);
    tick();
    checkOutput({tag, ".no_mem_rd"}, mem_rd, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_write(input string tag, input logic rd_too, input logic [31:0] addr,
                          input logic [31:0] data);
    applyStimulus(rd_too, 1'b1, addr, data);
    checkOutput({tag, ".stall"}, ready, 0);
    wait_mem(1'b1);
    checkOutput({tag, ".mem_wr"}, mem_wr, 1);
    checkOutput({tag, ".mem_addr"}, mem_addr, addr - 32'd1024);
    checkOutput({tag, ".mem_wdata"}, mem_wdata, data);
    checkOutput({tag, ".mem_rd"}, mem_rd, 0);
    tick();
    checkOutput({tag, ".hold"}, {ready, mem_wr}, 2'b01);
    mem_ready = 1'b1;
    #1;
    checkOutput({tag, ".ready"}, ready, 1);
    tick();
    mem_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput({tag, ".mem_wr_low"}, mem_wr, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("reset.ready", ready, 1);
    checkOutput("reset.mem", {mem_rd, mem_wr}, 2'b00);
    checkOutput("reset.rdata", cpu_rdata, 32'h0);
    checkOutput("reset.hits", hit_count, 0);
    checkOutput("reset.misses", miss_count, 0);

    read_miss("miss1024", 32'd1024, 32'h0, 64'hBBBB_0000_AAAA_0000, 32'hAAAA_0000);
    checkOutput("miss1024.count", miss_count, 1);
    read_hit("hit1028", 32'd1028, 32'hBBBB_0000);
    checkOutput("hit1028.count", hit_count, 1);

    // Set 0 holds tags 0 (1024), 1 (1536), 2 (2048).
    read_hit("lru.hit1024a", 32'd1024, 32'hAAAA_0000);
    read_miss("lru.miss1536", 32'd1536, 32'h200, 64'h2222_2222_1111_1111, 32'h1111_1111);
    read_hit("lru.hit1024b", 32'd1024, 32'hAAAA_0000);
    read_miss("lru.miss2048", 32'd2048, 32'h400, 64'h4444_4444_3333_3333, 32'h3333_3333);
    read_hit("lru.hit1024c", 32'd1024, 32'hAAAA_0000);
    read_miss("lru.miss1536b", 32'd1536, 32'h200, 64'h2222_2222_1111_1111, 32'h1111_1111);
    read_hit("lru.hit1536", 32'd1540, 32'h2222_2222);
    checkOutput("lru.hits", hit_count, 5);
    checkOutput("lru.misses", miss_count, 4);

    do_write("wr1028", 1'b0, 32'd1028, 32'h1234_5678);
    read_hit("wr1028.rd", 32'd1028, 32'h1234_5678);
    read_hit("wr1028.other", 32'd1024, 32'hAAAA_0000);
    checkOutput("hits.saturate_edge", hit_count, 7);

    do_write("wrboth", 1'b1, 32'd1028, 32'hCAFE_F00D);
    checkOutput("wrboth.no_hit", hit_count, 7);
    read_hit("wrboth.rd", 32'd1028, 32'hCAFE_F00D);
    checkOutput("hits.saturated", hit_count, 7);

    do_write("wr1100", 1'b0, 32'd1100, 32'h5A5A_A5A5);
    read_miss("rd1100", 32'd1100, 32'h48, 64'h6666_6666_5555_5555, 32'h6666_6666);
    checkOutput("rd1100.count", miss_count, 5);

    // Reset in the middle of a miss; the late mem_ready must be ignored.
    applyStimulus(1'b1, 1'b0, 32'd2048, 32'h0);
    wait_mem(1'b0);
    checkOutput("rstmiss.mem_rd", mem_rd, 1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    checkOutput("rstmiss.mem_rd_low", mem_rd, 0);
    mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checkOutput("rstmiss.counts", {hit_count, miss_count}, 0);
    checkOutput("rstmiss.mem_rd_late", mem_rd, 0);
    read_miss("rstmiss.rd1024", 32'd1024, 32'h0, 64'h0000_0002_0000_0001, 32'h0000_0001);
    checkOutput("rstmiss.miss_after", miss_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
